// File: rtl/interrupt_request_controller_pkg.sv
// Shared encodings for the interrupt request controller: request kinds,
// vector addresses and FSM states.
package interrupt_request_controller_pkg;

  typedef enum logic [1:0] {
    KIND_RESET = 2'b00,
    KIND_NMI   = 2'b01,
    KIND_IRQ   = 2'b10,
    KIND_BRK   = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } state_e;

  localparam logic [15:0] VEC_RESET   = 16'hFFFC;
  localparam logic [15:0] VEC_NMI     = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ_BRK = 16'hFFFE;

  function automatic logic [15:0] kind_vector(input kind_e k);
    case (k)
      KIND_RESET: kind_vector = VEC_RESET;
      KIND_NMI:   kind_vector = VEC_NMI;
      default:    kind_vector = VEC_IRQ_BRK;
    endcase
  endfunction

  // Larger rank wins: RESET > NMI > BRK > IRQ.
  function automatic logic [1:0] kind_rank(input kind_e k);
    case (k)
      KIND_RESET: kind_rank = 2'd3;
      KIND_NMI:   kind_rank = 2'd2;
      KIND_BRK:   kind_rank = 2'd1;
      default:    kind_rank = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_request_controller_int_sync.sv
// Multi-stage synchronizer for active-low asynchronous inputs; flops reset
// to the inactive (high) level.
module int_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_request_controller.sv
// Interrupt request controller: latches RESET/NMI/BRK, tracks level IRQ,
// and arbitrates one request at a time through IDLE/REQ/SERVICE.
module interrupt_request_controller
  import interrupt_request_controller_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_reset_n,
  input  logic [7:0]  ppu_status,
  input  logic [7:0]  ppu_ctrl,
  input  logic        irq_n,
  input  logic        break_flag,
  input  logic        i_flag,
  input  logic        int_ack,
  input  logic        int_done,
  output logic        int_req,
  output logic [1:0]  int_kind,
  output logic [15:0] vector_addr,
  output logic        busy,
  output logic [7:0]  nmi_count
);

  logic irq_n_s, soft_n_s;

  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq (
    .clk (clk),
    .rst (rst),
    .d_i (irq_n),
    .q_o (irq_n_s)
  );

  int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_soft (
    .clk (clk),
    .rst (rst),
    .d_i (soft_reset_n),
    .q_o (soft_n_s)
  );

  state_e      state_q;
  kind_e       int_kind_q;
  logic        int_req_q, busy_q;
  logic [15:0] vector_q;
  logic        rst_pend_q, rst_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        brk_pend_q, brk_pend_d;
  logic        nmi_prev_q;
  logic [7:0]  nmi_count_q, nmi_count_d;

  logic  nmi_line, nmi_edge, irq_elig, latched_elig, any_elig, ack_take;
  kind_e best_kind;
  logic  unused_ppu_bits;

  assign nmi_line        = ppu_status[7] & ppu_ctrl[7];
  assign nmi_edge        = nmi_line & ~nmi_prev_q;
  assign irq_elig        = ~irq_n_s & ~i_flag;
  assign latched_elig    = rst_pend_q | nmi_pend_q | brk_pend_q;
  assign any_elig        = latched_elig | irq_elig;
  assign ack_take        = (state_q == ST_REQ) && int_ack;
  assign unused_ppu_bits = ^{ppu_status[6:0], ppu_ctrl[6:0]};

  always_comb begin
    best_kind = KIND_IRQ;
    if (rst_pend_q)      best_kind = KIND_RESET;
    else if (nmi_pend_q) best_kind = KIND_NMI;
    else if (brk_pend_q) best_kind = KIND_BRK;
  end

  // Set terms are OR-ed after the clear so a same-cycle set survives.
  always_comb begin
    rst_pend_d  = (rst_pend_q & ~(ack_take && int_kind_q == KIND_RESET)) | ~soft_n_s;
    nmi_pend_d  = (nmi_pend_q & ~(ack_take && int_kind_q == KIND_NMI)) | nmi_edge;
    brk_pend_d  = (brk_pend_q & ~(ack_take && int_kind_q == KIND_BRK)) | break_flag;
    nmi_count_d = nmi_edge ? nmi_count_q + 8'd1 : nmi_count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_pend_q  <= 1'b1;
      nmi_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      nmi_prev_q  <= 1'b0;
      nmi_count_q <= '0;
    end else begin
      rst_pend_q  <= rst_pend_d;
      nmi_pend_q  <= nmi_pend_d;
      brk_pend_q  <= brk_pend_d;
      nmi_prev_q  <= nmi_line;
      nmi_count_q <= nmi_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      int_req_q  <= 1'b0;
      int_kind_q <= KIND_RESET;
      vector_q   <= VEC_RESET;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            state_q    <= ST_REQ;
            int_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            int_kind_q <= best_kind;
            vector_q   <= kind_vector(best_kind);
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state_q   <= ST_SERVICE;
            int_req_q <= 1'b0;
          end else if (int_kind_q == KIND_IRQ && !irq_elig && !latched_elig) begin
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (any_elig && kind_rank(best_kind) > kind_rank(int_kind_q)) begin
            int_kind_q <= best_kind;
            vector_q   <= kind_vector(best_kind);
          end
        end
        ST_SERVICE: begin
          if (int_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          int_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign int_req     = int_req_q;
  assign int_kind    = int_kind_q;
  assign vector_addr = vector_q;
  assign busy        = busy_q;
  assign nmi_count   = nmi_count_q;

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Directed-vector bench for interrupt_request_controller.
module tb_interrupt_request_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        soft_reset_n = 1'b1;
  logic [7:0]  ppu_status = 8'h00;
  logic [7:0]  ppu_ctrl = 8'h00;
  logic        irq_n = 1'b1;
  logic        break_flag = 1'b0;
  logic        i_flag = 1'b0;
  logic        int_ack = 1'b0;
  logic        int_done = 1'b0;
  logic        int_req;
  logic [1:0]  int_kind;
  logic [15:0] vector_addr;
  logic        busy;
  logic [7:0]  nmi_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  interrupt_request_controller #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .soft_reset_n (soft_reset_n),
    .ppu_status   (ppu_status),
    .ppu_ctrl     (ppu_ctrl),
    .irq_n        (irq_n),
    .break_flag   (break_flag),
    .i_flag       (i_flag),
    .int_ack      (int_ack),
    .int_done     (int_done),
    .int_req      (int_req),
    .int_kind     (int_kind),
    .vector_addr  (vector_addr),
    .busy         (busy),
    .nmi_count    (nmi_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    int_done = 1'b1;
    tick(1);
    int_done = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic req, input logic [1:0] kind,
                           input logic [15:0] vec);
    check_eq({tag, "_req"}, 32'(int_req), 32'(req));
    check_eq({tag, "_kind"}, 32'(int_kind), 32'(kind));
    check_eq({tag, "_vec"}, 32'(vector_addr), 32'(vec));
  endtask

  task automatic check_reset_vals(input string tag);
    check_req(tag, 1'b0, 2'b00, 16'hFFFC);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_cnt"}, 32'(nmi_count), 32'd0);
  endtask

  initial begin
    // Power-on reset, then the mandatory RESET request.
    tick(2);
    check_reset_vals("por");
    rst = 1'b1;
    tick(1);
    check_req("rst_first", 1'b1, 2'b00, 16'hFFFC);
    check_eq("rst_first_busy", 32'(busy), 32'd1);
    pulse_ack();
    check_eq("svc_req", 32'(int_req), 32'd0);
    check_eq("svc_busy", 32'(busy), 32'd1);
    pulse_ack();
    check_eq("svc_ack_ignored", 32'(busy), 32'd1);
    pulse_done();
    check_eq("idle_busy", 32'(busy), 32'd0);
    tick(1);
    check_eq("idle_no_req", 32'(int_req), 32'd0);

    // NMI edge with NMI enabled.
    ppu_ctrl = 8'h80;
    ppu_status = 8'h80;
    tick(1);
    check_eq("nmi_cnt1", 32'(nmi_count), 32'd1);
    check_eq("nmi_lat", 32'(int_req), 32'd0);
    tick(1);
    check_req("nmi", 1'b1, 2'b01, 16'hFFFA);
    pulse_ack();
    pulse_done();
    ppu_status = 8'h00;
    tick(1);
    check_eq("nmi_done", 32'(int_req), 32'd0);

    // Same vblank edge with NMI disabled.
    ppu_ctrl = 8'h00;
    ppu_status = 8'h80;
    tick(3);
    check_eq("nmi_dis_req", 32'(int_req), 32'd0);
    check_eq("nmi_dis_cnt", 32'(nmi_count), 32'd1);
    ppu_status = 8'h00;
    ppu_ctrl = 8'h80;
    tick(1);

    // IRQ, then upgrade to NMI before ack; IRQ follows after done.
    irq_n = 1'b0;
    tick(2);
    check_eq("irq_sync_lat", 32'(int_req), 32'd0);
    tick(1);
    check_req("irq", 1'b1, 2'b10, 16'hFFFE);
    ppu_status = 8'h80;
    tick(2);
    check_req("upg", 1'b1, 2'b01, 16'hFFFA);
    check_eq("upg_cnt", 32'(nmi_count), 32'd2);
    pulse_ack();
    check_eq("upg_ack", 32'(int_req), 32'd0);
    ppu_status = 8'h00;
    pulse_done();
    tick(1);
    check_req("irq_after", 1'b1, 2'b10, 16'hFFFE);

    // IRQ withdrawn when the line releases.
    irq_n = 1'b1;
    tick(2);
    check_eq("wd_still", 32'(int_req), 32'd1);
    tick(1);
    check_eq("wd_req", 32'(int_req), 32'd0);
    check_eq("wd_busy", 32'(busy), 32'd0);

    // Masked IRQ; BRK ignores i_flag.
    i_flag = 1'b1;
    irq_n = 1'b0;
    tick(4);
    check_eq("irq_masked", 32'(int_req), 32'd0);
    break_flag = 1'b1;
    tick(1);
    break_flag = 1'b0;
    tick(1);
    check_req("brk", 1'b1, 2'b11, 16'hFFFE);
    pulse_ack();
    pulse_done();
    irq_n = 1'b1;
    tick(3);
    i_flag = 1'b0;
    tick(1);
    check_eq("brk_done", 32'(int_req), 32'd0);

    // Simultaneous BRK and NMI: NMI first, then BRK.
    ppu_status = 8'h80;
    break_flag = 1'b1;
    tick(1);
    break_flag = 1'b0;
    tick(1);
    check_req("prio_nmi", 1'b1, 2'b01, 16'hFFFA);
    pulse_ack();
    ppu_status = 8'h00;
    pulse_done();
    tick(1);
    check_req("prio_brk", 1'b1, 2'b11, 16'hFFFE);
    pulse_ack();
    pulse_done();
    tick(1);
    check_eq("prio_done", 32'(int_req), 32'd0);

    // NMI edge on the ack cycle survives the clear.
    ppu_status = 8'h80;
    tick(2);
    check_req("nmi2", 1'b1, 2'b01, 16'hFFFA);
    ppu_status = 8'h00;
    tick(1);
    ppu_status = 8'h80;
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    check_eq("ackedge_req", 32'(int_req), 32'd0);
    check_eq("ackedge_cnt", 32'(nmi_count), 32'd5);
    pulse_done();
    tick(1);
    check_req("nmi_again", 1'b1, 2'b01, 16'hFFFA);

    // int_done outside SERVICE does nothing.
    pulse_done();
    check_eq("done_in_req", 32'(int_req), 32'd1);
    check_eq("done_in_req_busy", 32'(busy), 32'd1);

    // Counter wrap: 251 more edges take 5 -> 0.
    for (int i = 0; i < 251; i++) begin
      ppu_status = 8'h00;
      tick(1);
      ppu_status = 8'h80;
      tick(1);
    end
    check_eq("wrap_cnt", 32'(nmi_count), 32'd0);
    check_eq("wrap_kind", 32'(int_kind), 32'd1);
    pulse_ack();
    pulse_done();
    ppu_status = 8'h00;
    tick(1);
    check_eq("wrap_done", 32'(int_req), 32'd0);

    // Soft reset button, then hard reset during SERVICE.
    soft_reset_n = 1'b0;
    tick(1);
    soft_reset_n = 1'b1;
    tick(2);
    check_eq("soft_lat", 32'(int_req), 32'd0);
    tick(1);
    check_req("soft", 1'b1, 2'b00, 16'hFFFC);
    pulse_ack();
    ppu_status = 8'h80;
    tick(1);
    check_eq("svc_nmi_cnt", 32'(nmi_count), 32'd1);
    ppu_status = 8'h00;
    rst = 1'b0;
    #1;
    check_reset_vals("abort_async");
    tick(1);
    check_reset_vals("abort_held");
    rst = 1'b1;
    tick(1);
    check_req("rerst", 1'b1, 2'b00, 16'hFFFC);
    pulse_ack();
    pulse_done();
    tick(1);
    check_eq("nmi_pend_cleared", 32'(int_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_request_controller.md
INTERRUPT_REQUEST_CONTROLLER -- requirements
Module: interrupt_request_controller

Interface
REQ-001 SHALL have parameter: SYNC_STAGES, 2, flop stages on irq_n and soft_reset_n (legal 1..4).
REQ-002 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: soft_reset_n  in  1  console reset button, active-low level.
REQ-005 SHALL have port: ppu_status  in  8  PPU status; bit 7 = vblank.
REQ-006 SHALL have port: ppu_ctrl  in  8  PPU control; bit 7 = NMI enable.
REQ-007 SHALL have port: irq_n  in  1  maskable IRQ from APU/mapper, active-low level.
REQ-008 SHALL have port: break_flag  in  1  one-cycle pulse when BRK decodes.
REQ-009 SHALL have port: i_flag  in  1  CPU status bit 2, interrupt disable.
REQ-010 SHALL have port: int_ack  in  1  handler accepted current request; one-cycle pulse.
REQ-011 SHALL have port: int_done  in  1  handler finished; one-cycle pulse.
REQ-012 SHALL have port: int_req  out  1  request to the interrupt handler.
REQ-013 SHALL have port: int_kind  out  2  00 RESET, 01 NMI, 10 IRQ, 11 BRK.
REQ-014 SHALL have port: vector_addr  out  16  low-byte vector address for int_kind.
REQ-015 SHALL have port: busy  out  1  high in REQ and SERVICE.
REQ-016 SHALL have port: nmi_count  out  8  NMI edges detected, wraps 255->0.

Function
REQ-017 Pending sources SHALL be latched: rst_pend (synced soft_reset_n low), nmi_pend (rising edge of ppu_status[7]&ppu_ctrl[7], previous value registered), brk_pend (break_flag high).
REQ-018 IRQ SHALL be level, not latched: eligible while synced irq_n==0 and i_flag==0.
REQ-019 Priority SHALL be RESET > NMI > BRK > IRQ; BRK SHALL ignore i_flag.
REQ-020 vector_addr SHALL be RESET 16'hFFFC, NMI 16'hFFFA, IRQ/BRK 16'hFFFE.
REQ-021 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-022 IDLE: any eligible source -> register kind/vector, int_req=1, go REQ; int_req asserts the cycle after the pending bit is set.
REQ-023 REQ: int_kind may only upgrade to higher priority, never downgrade; value on int_ack cycle is the accepted kind.
REQ-024 REQ with int_ack: clear pending bit of accepted kind (none for IRQ), int_req=0, go SERVICE.
REQ-025 REQ, kind IRQ, irq_n released or i_flag set, no other eligible source, no int_ack: withdraw -- int_req=0, go IDLE.
REQ-026 SERVICE: ignore int_ack; int_done -> IDLE; new events keep latching and are serviced after return.
REQ-027 Same-cycle set and clear of a pending bit SHALL leave it set.
REQ-028 NMI edge while nmi_pend already set SHALL merge (one service) but still increment nmi_count.
REQ-029 int_done outside SERVICE SHALL be ignored.

Reset
REQ-030 On rst low: state IDLE, int_req 0, int_kind 00, vector_addr 16'hFFFC, busy 0, nmi_count 0, nmi_pend 0, brk_pend 0, sync flops 1, edge register 0.
REQ-031 rst_pend SHALL reset to 1, so the first request after rst release is RESET.
REQ-032 rst asserted mid-REQ/SERVICE SHALL abort immediately to reset values.

Structure
REQ-033 Shared package SHALL hold kind encodings, the three vector constants and FSM state encodings.
REQ-034 One sub-module SHALL exist: int_sync, SYNC_STAGES-deep synchronizer, instantiated for irq_n and soft_reset_n.

Verification
REQ-035 Release rst, no events -> int_req=1, int_kind=00, vector_addr=FFFC; ack -> SERVICE; done -> IDLE, int_req stays 0.
REQ-036 ppu_ctrl=80h, ppu_status 00h->80h -> nmi_count+1, int_kind=01, vector=FFFA; ppu_ctrl=00h same edge -> no request.
REQ-037 irq_n=0, i_flag=0 -> kind 10; NMI edge before ack -> kind upgrades to 01; ack -> NMI serviced, IRQ serviced after done.
REQ-038 irq_n=0 then irq_n=1 before ack -> int_req drops, IDLE; with i_flag=1 irq_n=0 -> no request; break_flag with i_flag=1 -> kind 11, FFFE.
REQ-039 NMI edge on int_ack cycle of NMI -> second NMI request follows done; 256 edges -> nmi_count wraps to 0.
REQ-040 rst low during SERVICE -> all outputs at REQ-030 values next cycle; release -> RESET request.
